// File: rtl/regfile_pkg.sv
// Shared constants and types for the architectural register file and its
// busy-bit scoreboard.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register marking an
// in-flight producer, plus a running count of busy registers.
// x0 can never be marked busy.
module scoreboard
    import regfile_pkg::reg_addr_t;
    import regfile_pkg::ZERO_REG;
#(
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_en,
    input  reg_addr_t        set_addr,
    input  logic             clr_en,
    input  reg_addr_t        clr_addr,
    output logic [NREGS-1:0] busy,
    output logic [5:0]       busy_count
);

    logic             set_valid;
    logic             clr_valid;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] busy_next;
    logic             count_inc;
    logic             count_dec;

    assign set_valid = set_en && (set_addr != ZERO_REG);
    assign clr_valid = clr_en && (clr_addr != ZERO_REG);

    // Decode the set/clear requests into one-hot masks (bit 0 never set).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        set_mask = '0;
        clr_mask = '0;
        for (int r = 1; r < NREGS; r++) begin
            set_mask[r] = set_valid && (set_addr == reg_addr_t'(r));
            clr_mask[r] = clr_valid && (clr_addr == reg_addr_t'(r));
        end
    end

    // Set wins over clear: a new producer issued in the same cycle as the
    // old producer's writeback owns the register.
    assign busy_next = (busy & ~clr_mask) | set_mask;

    // Count only real transitions: a set of an already-busy register, a
    // clear of an idle one, or a same-register set+clear change nothing.
    assign count_inc = set_valid && !busy[set_addr];
    assign count_dec = clr_valid && busy[clr_addr] &&
                       !(set_valid && (set_addr == clr_addr));

    // Busy vector and count state.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= busy_count + 6'(count_inc) - 6'(count_dec);
        end
    end

    a_zero_never_busy: assert property (
        @(posedge clk) disable iff (!reset_n) !busy[0]);

    a_count_matches: assert property (
        @(posedge clk) disable iff (!reset_n) busy_count == 6'($countones(busy)));

    a_count_range: assert property (
        @(posedge clk) disable iff (!reset_n) busy_count <= 6'(NREGS - 1));

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file (x0..x31) with combinational read ports,
// same-cycle writeback bypass and a busy-bit scoreboard that stalls issue on
// RAW and WAW hazards.
module regfile_scoreboard
    import regfile_pkg::reg_addr_t;
    import regfile_pkg::ZERO_REG;
#(
    parameter int XLEN  = regfile_pkg::XLEN,
    parameter int NREGS = regfile_pkg::NREGS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            reg_wr_en,
    input  reg_addr_t       reg_wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_ready,
    output logic            rs2_ready,
    input  logic            issue_en,
    input  logic            issue_has_rd,
    input  reg_addr_t       issue_rd,
    output logic            issue_stall,
    output logic [5:0]      busy_count
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             wb_hit_rd;
    logic             issue_accept;

    // Register array: writeback writes regardless of busy state; x0 is never written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this array is reset because architectural registers must read 0 after reset; plain RAMs normally are not.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_wr_en && (reg_wr_addr != ZERO_REG)) begin
            regs[reg_wr_addr] <= wr_data;
        end
    end

    assign rs1_hit = reg_wr_en && (reg_wr_addr == rs1_addr) && (rs1_addr != ZERO_REG);
    assign rs2_hit = reg_wr_en && (reg_wr_addr == rs2_addr) && (rs2_addr != ZERO_REG);

    // Source port 1: bypass the in-flight writeback, else read the array.
    always_comb begin
        rs1_data = '0;
        if (rs1_hit) begin
            rs1_data = wr_data;
        end else if (rs1_addr != ZERO_REG) begin
            rs1_data = regs[rs1_addr];
        end
    end

    // Source port 2: same structure as port 1.
    always_comb begin
        rs2_data = '0;
        if (rs2_hit) begin
            rs2_data = wr_data;
        end else if (rs2_addr != ZERO_REG) begin
            rs2_data = regs[rs2_addr];
        end
    end

    // A busy source is still usable when its producer writes back this cycle.
    assign rs1_ready = !busy[rs1_addr] || rs1_hit;
    assign rs2_ready = !busy[rs2_addr] || rs2_hit;

    // WAW is resolved when the old producer retires in the same cycle.
    assign wb_hit_rd = reg_wr_en && (reg_wr_addr == issue_rd);

    assign issue_stall = issue_en &&
                         (!rs1_ready || !rs2_ready ||
                          (issue_has_rd && (issue_rd != ZERO_REG) &&
                           busy[issue_rd] && !wb_hit_rd));

    assign issue_accept = issue_en && !issue_stall;

    scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .set_en     (issue_accept && issue_has_rd),
        .set_addr   (issue_rd),
        .clr_en     (reg_wr_en),
        .clr_addr   (reg_wr_addr),
        .busy       (busy),
        .busy_count (busy_count)
    );

endmodule
